if_stage: RTL

- Instruction-fetch stage of the RV32I core, directly upstream of the instruction memory.
- Holds the PC and drives the word address into the memory's combinational read port.
- Captures the returned instruction with its PC into a small fetch queue.
- Presents queue entries to decode over a valid/ready handshake; branch/jump redirects from execute flush the queue and reload the PC.

---
 rtl/if_pkg.sv | 17 +
 rtl/if_stage_fetch_queue.sv | 67 ++++++
 rtl/if_stage.sv | 125 ++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package if_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        misalign;
   } fetch_entry_t;

   function automatic logic [31:0] align_pc(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_stage_fetch_queue.sv
// Small synchronous FIFO of fetch entries; clear beats push, head is read
// straight from the storage registers.
module fetch_queue
   import if_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     clear_i,
   input  logic                     push_i,
   input  fetch_entry_t             push_data_i,
   input  logic                     pop_i,
   output fetch_entry_t             head_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   fetch_entry_t   mem_q [DEPTH];
   logic [PW-1:0]  rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           do_pop, do_push;

   assign do_pop  = pop_i & (cnt_q != '0);
   assign do_push = push_i & ((cnt_q < DEPTH_C) | do_pop);

   // Pointer and occupancy next state.
   always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (clear_i) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + PW'(1);
         else         wr_d = wr_q;
         if (do_pop)  rd_d = rd_q + PW'(1);
         else         rd_d = rd_q;
         cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push & ~clear_i & ~rst_i) mem_q[wr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: PC, imem address, fetch queue and redirect.
// Optional misaligned-target trapping is enabled by IF_MISALIGN_CHK_EN.
module if_stage
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          ADDR_W   = 12,
   parameter int          QDEPTH   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_en,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [31:0]       id_instr,
   output logic [31:0]       id_pc,
   output logic [31:0]       id_pc_plus4
`ifdef IF_MISALIGN_CHK_EN
   ,output logic             id_misalign
`endif
);

   localparam int CW = $clog2(QDEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] q_count;
   fetch_entry_t  q_head, push_entry;
   logic          pop, push, fetch_blocked, misalign_pend;

`ifdef IF_MISALIGN_CHK_EN
   logic halt_q, halt_d, pend_q, pend_d;

   assign fetch_blocked = halt_q;
   assign misalign_pend = pend_q;

   // A misaligned target emits one marker entry, then fetch parks until the next redirect.
   always_comb begin
      halt_d = halt_q;
      pend_d = pend_q;
      if (redirect_valid) begin
         pend_d = (redirect_pc[1:0] != 2'b00);
         halt_d = 1'b0;
      end else if (push & pend_q) begin
         pend_d = 1'b0;
         halt_d = 1'b1;
      end else begin
         pend_d = pend_q;
         halt_d = halt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         halt_q <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         halt_q <= halt_d;
         pend_q <= pend_d;
      end
   end

   assign id_misalign = id_valid & q_head.misalign;
`else
   logic [2:0] unused_bits;

   assign fetch_blocked = 1'b0;
   assign misalign_pend = 1'b0;
   assign unused_bits   = {q_head.misalign, redirect_pc[1:0]};
`endif

   assign pop  = id_valid & id_ready;
   assign push = fetch_en & ~redirect_valid & ~fetch_blocked &
                 ((q_count < DEPTH_C) | pop);

   always_comb begin
      push_entry.pc       = pc_q;
      push_entry.instr    = imem_rdata;
      push_entry.misalign = 1'b0;
      if (misalign_pend) begin
         push_entry.instr    = NOP_INSTR;
         push_entry.misalign = 1'b1;
      end else begin
         push_entry.instr    = imem_rdata;
         push_entry.misalign = 1'b0;
      end
   end

   // The marker entry does not consume a PC slot, so pc holds while it is pushed.
   always_comb begin
      pc_d = pc_q;
      if (redirect_valid)               pc_d = align_pc(redirect_pc);
      else if (push & ~misalign_pend)   pc_d = pc_q + 32'd4;
      else                              pc_d = pc_q;
   end

   always_ff @(posedge clk) begin
      if (rst) pc_q <= RESET_PC;
      else     pc_q <= pc_d;
   end

   fetch_queue #(
      .DEPTH (QDEPTH)
   ) u_queue (
      .clk_i       (clk),
      .rst_i       (rst),
      .clear_i     (redirect_valid),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .head_o      (q_head),
      .count_o     (q_count)
   );

   assign imem_addr   = pc_q[ADDR_W+1:2];
   assign id_valid    = (q_count != '0);
   assign id_instr    = id_valid ? q_head.instr : NOP_INSTR;
   assign id_pc       = id_valid ? q_head.pc    : 32'h0000_0000;
   assign id_pc_plus4 = id_pc + 32'd4;

endmodule
